// File: rtl/btp_pkg.sv
// Shared types and constants for the branch target predictor.
// Pure declarations, no logic or latency of its own.
// No flow control; consumers are single-cycle combinational/registered logic.
package btp_pkg;

    // Kind of control-flow instruction sitting in execute.
    typedef enum logic [1:0] {
        BK_BRANCH = 2'b00,
        BK_JAL    = 2'b01,
        BK_JALR   = 2'b10,
        BK_RSVD   = 2'b11
    } ex_kind_e;

    // 2-bit saturating counter landmarks; ctr >= CTR_WEAK_T means predict taken.
    localparam logic [1:0] CTR_ZERO     = 2'd0;
    localparam logic [1:0] CTR_WEAK_T   = 2'd2;
    localparam logic [1:0] CTR_STRONG_T = 2'd3;

    // Widest XLEN the entry struct can hold; narrower configs zero-extend
    // tag and target into these fields and the unused upper bits stay 0.
    localparam int BTP_MAX_XLEN = 64;

    typedef struct packed {
        logic                    valid;
        logic [1:0]              ctr;
        logic [BTP_MAX_XLEN-1:0] tag;
        logic [BTP_MAX_XLEN-1:0] target;
    } btb_entry_t;

    // Saturating step of a 2-bit counter: up on taken, down on not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == CTR_STRONG_T) ? ctr : ctr + 2'd1;
        end
        return (ctr == CTR_ZERO) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_addr_calc.sv
// Computes JAL, JALR (LSB cleared), branch and fall-through addresses.
// Latency: purely combinational, 0 cycles.
// No backpressure; outputs follow inputs every cycle.
module branch_addr_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] j_imm,
    input  logic [XLEN-1:0] b_imm,
    output logic [XLEN-1:0] jal_tgt,
    output logic [XLEN-1:0] jalr_tgt,
    output logic [XLEN-1:0] br_tgt,
    output logic [XLEN-1:0] seq_pc
);

    logic [XLEN-1:0] jalr_sum;

    // All sums wrap modulo 2^XLEN; overflow is intentionally ignored.
    always_comb begin
        jalr_sum = rs1 + i_imm;
        jal_tgt  = pc + j_imm;
        jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
        br_tgt   = pc + b_imm;
        seq_pc   = pc + XLEN'(4);
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Resolves execute-stage control flow and keeps a direct-mapped BTB for fetch.
// Latency: resolve/lookup outputs combinational; BTB writes visible next cycle.
// No backpressure; one update per cycle. Optional BTP_STATS_EN adds stat counters.
module branch_target_predictor
    import btp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch-side lookup
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    // execute-side resolution
    input  logic            ex_valid,
    input  logic [1:0]      ex_kind,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_i_imm,
    input  logic [XLEN-1:0] ex_j_imm,
    input  logic [XLEN-1:0] ex_b_imm,
    input  logic            ex_cond,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] ex_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misaligned,
`ifdef BTP_STATS_EN
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispredicts,
`endif
    input  logic            invalidate
);

    localparam int IDXW = $clog2(ENTRIES);

    // ------------------------------------------------------------------
    // Target computation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] jal_tgt;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] seq_pc;

    branch_addr_calc #(
        .XLEN (XLEN)
    ) u_addr_calc (
        .pc       (ex_pc),
        .rs1      (ex_rs1),
        .i_imm    (ex_i_imm),
        .j_imm    (ex_j_imm),
        .b_imm    (ex_b_imm),
        .jal_tgt  (jal_tgt),
        .jalr_tgt (jalr_tgt),
        .br_tgt   (br_tgt),
        .seq_pc   (seq_pc)
    );

    logic            ex_vld_eff;
    logic            is_branch;
    logic            actual_taken;
    logic [XLEN-1:0] tgt_c;

    // Resolve the instruction; the reserved kind behaves as no instruction.
    always_comb begin
        ex_vld_eff   = ex_valid && (ex_kind != BK_RSVD);
        is_branch    = (ex_kind == BK_BRANCH);
        case (ex_kind)
            BK_JAL:  tgt_c = jal_tgt;
            BK_JALR: tgt_c = jalr_tgt;
            default: tgt_c = br_tgt;
        endcase
        actual_taken = !is_branch || ex_cond;
    end

    // Execute-stage outputs, all gated by an effective valid.
    always_comb begin
        ex_target   = ex_vld_eff ? tgt_c : '0;
        mispredict  = ex_vld_eff &&
                      ((ex_pred_taken != actual_taken) ||
                       (actual_taken && (ex_pred_target != tgt_c)));
        redirect_pc = ex_vld_eff ? (actual_taken ? tgt_c : seq_pc) : '0;
        misaligned  = ex_vld_eff && actual_taken && tgt_c[1];
    end

    // ------------------------------------------------------------------
    // BTB storage and lookup
    // ------------------------------------------------------------------
    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];

    logic [IDXW-1:0]         fetch_idx;
    logic [BTP_MAX_XLEN-1:0] fetch_tag;
    btb_entry_t              rd_e;

    // Lookup reads registered state only, so a same-cycle write is not seen.
    always_comb begin
        fetch_idx   = fetch_pc[IDXW+1:2];
        fetch_tag   = BTP_MAX_XLEN'(fetch_pc >> (IDXW + 2));
        rd_e        = btb_q[fetch_idx];
        pred_taken  = rd_e.valid && (rd_e.tag == fetch_tag) && (rd_e.ctr >= CTR_WEAK_T);
        pred_target = pred_taken ? XLEN'(rd_e.target) : '0;
    end

    // Upper struct bits beyond XLEN and the PC byte offset carry no information.
    logic unused_bits;
    assign unused_bits = ^{rd_e, fetch_pc[1:0]};

    // ------------------------------------------------------------------
    // BTB update
    // ------------------------------------------------------------------
    logic [IDXW-1:0]         ex_idx;
    logic [BTP_MAX_XLEN-1:0] ex_tag;
    btb_entry_t              cur_e;
    btb_entry_t              new_e;
    logic                    ex_hit;
    logic                    upd_en;

    // Build the replacement entry for the execute PC's slot.
    always_comb begin
        ex_idx = ex_pc[IDXW+1:2];
        ex_tag = BTP_MAX_XLEN'(ex_pc >> (IDXW + 2));
        cur_e  = btb_q[ex_idx];
        ex_hit = cur_e.valid && (cur_e.tag == ex_tag);
        new_e  = cur_e;
        if (ex_hit) begin
            new_e.target = BTP_MAX_XLEN'(tgt_c);
            new_e.ctr    = is_branch ? ctr_step(cur_e.ctr, ex_cond) : CTR_STRONG_T;
        end else begin
            new_e.valid  = 1'b1;
            new_e.tag    = ex_tag;
            new_e.target = BTP_MAX_XLEN'(tgt_c);
            new_e.ctr    = is_branch ? CTR_WEAK_T : CTR_STRONG_T;
        end
        // A target with bit 1 set is never stored; hits refresh, taken misses allocate.
        upd_en = ex_vld_eff && !tgt_c[1] && (ex_hit || actual_taken);
    end

    // Next table state; invalidate wins over a same-cycle update.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            btb_d[i] = btb_q[i];
        end
        if (invalidate) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_d[i].valid = 1'b0;
            end
        end else if (upd_en) begin
            btb_d[ex_idx] = new_e;
        end
    end

    // Table register; async reset wipes every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= btb_d[i];
            end
        end
    end

`ifdef BTP_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (wrap naturally, untouched by invalidate)
    // ------------------------------------------------------------------
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Next counter values.
    always_comb begin
        stat_lookups_d     = stat_lookups_q + 32'd1;
        stat_hits_d        = stat_hits_q + {31'd0, pred_taken};
        stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
